// File: rtl/store_rmw_unit.sv
// store_rmw_unit: narrows a 32-bit register value into byte/half/word stores
// against a word-only synchronous data RAM. Sub-word stores read the target
// word, merge the new lane(s) and write it back; word stores write directly.
// Misaligned or illegal-size requests pulse misalign_err and never touch memory.
// Optional feature macro: STORE_BYTE_STROBE_EN (adds mem_be byte enables and
// turns sub-word stores into single writes with replicated data).
module store_rmw_unit #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_data,
  input  logic [1:0]           req_size,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 mem_wr_en,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 done,
`ifdef STORE_BYTE_STROBE_EN
  output logic [3:0]           mem_be,
`endif
  output logic                 misalign_err
);

  // The lane arithmetic below assumes exactly four byte lanes.
  if (DATA_SIZE != 32) begin : g_bad_data_size
    $error("store_rmw_unit: DATA_SIZE must be 32");
  end

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

  state_t state;
  state_t next_state;
  logic   accept;
  logic   misaligned;

  assign accept = req_valid && (state == IDLE);

  // Halves must sit on even addresses, words on multiples of four, size 11 is illegal.
  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef STORE_BYTE_STROBE_EN
  logic [3:0] be_reg;
`else
  logic [1:0]  lat_lane;
  logic [15:0] lat_data;
  logic        lat_half;
  logic [31:0] merged;

  // Overlay the latched byte/half onto the word read back from memory.
  always_comb begin
    merged = mem_rdata;
    if (lat_half) begin
      merged[{lat_lane[1], 4'b0000} +: 16] = lat_data;
    end else begin
      merged[{lat_lane, 3'b000} +: 8] = lat_data[7:0];
    end
  end
`endif

  // State register; reset abandons any in-flight read-modify-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-decoded strobes.
  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    done         = 1'b0;
    misalign_err = 1'b0;
`ifdef STORE_BYTE_STROBE_EN
    mem_be       = 4'b0000;
`endif
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misaligned) begin
            next_state = ERR;
          end else if (req_size == 2'b10) begin
            next_state = WRITE;
          end else begin
`ifdef STORE_BYTE_STROBE_EN
            next_state = WRITE;
`else
            next_state = READ;
`endif
          end
        end
      end
      READ: begin
        mem_rd_en  = 1'b1;
        next_state = MERGE;
      end
      MERGE: begin
        next_state = WRITE;
      end
      WRITE: begin
        mem_wr_en  = 1'b1;
        done       = 1'b1;
`ifdef STORE_BYTE_STROBE_EN
        mem_be     = be_reg;
`endif
        next_state = IDLE;
      end
      ERR: begin
        misalign_err = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch and registered memory address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef STORE_BYTE_STROBE_EN
      be_reg    <= 4'b0000;
`else
      lat_lane  <= 2'b00;
      lat_data  <= 16'h0000;
      lat_half  <= 1'b0;
`endif
    end else if (accept && !misaligned) begin
      mem_addr <= {req_addr[ADDR_SIZE-1:2], 2'b00};
`ifdef STORE_BYTE_STROBE_EN
      unique case (req_size)
        2'b00: begin
          mem_wdata <= {4{req_data[7:0]}};
          be_reg    <= 4'b0001 << req_addr[1:0];
        end
        2'b01: begin
          mem_wdata <= {2{req_data[15:0]}};
          be_reg    <= req_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem_wdata <= req_data;
          be_reg    <= 4'b1111;
        end
      endcase
`else
      lat_lane <= req_addr[1:0];
      lat_data <= req_data[15:0];
      lat_half <= req_size[0];
      if (req_size == 2'b10) begin
        mem_wdata <= req_data;
      end
`endif
    end
`ifndef STORE_BYTE_STROBE_EN
    else if (state == MERGE) begin
      mem_wdata <= merged;
    end
`endif
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: table-driven, scoreboarded bench for store_rmw_unit.
// Each vector pushes its expected write/error onto a queue when driven; the
// checker pops it when the DUT strobes mem_wr_en or misalign_err.
// Honours STORE_BYTE_STROBE_EN to select the byte-enable expectations.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata = '0;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        done;
  logic        misalign_err;
  logic [3:0]  be_seen;
  logic [31:0] resp_word = '0;

`ifdef STORE_BYTE_STROBE_EN
  logic [3:0]  mem_be;
  assign be_seen = mem_be;
`else
  assign be_seen = 4'b0000;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  store_rmw_unit #(.ADDR_SIZE(32), .DATA_SIZE(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_size(req_size),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .done(done),
`ifdef STORE_BYTE_STROBE_EN
    .mem_be(mem_be),
`endif
    .misalign_err(misalign_err)
  );

  // Memory model: read data valid only in the cycle after a read strobe.
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? resp_word : 32'hBAD0BAD0;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wdata;
    logic [31:0] sb_wdata;
    logic [3:0]  be;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    int          rds;
  } exp_t;

  vec_t vecs[12];
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    e.err  = v.err;
    e.addr = {v.addr[31:2], 2'b00};
`ifdef STORE_BYTE_STROBE_EN
    e.wdata = v.sb_wdata;
    e.be    = v.be;
    e.lat   = 1;
    e.rds   = 0;
`else
    e.wdata = v.wdata;
    e.be    = 4'b0000;
    e.lat   = (v.err || v.size == 2'b10) ? 1 : 3;
    e.rds   = (e.lat == 3) ? 1 : 0;
`endif
    sbq.push_back(e);
    resp_word = v.rdata;
    @(negedge clk);
    check({tag, ".ready_before"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_data  = 32'hFFFF_FFFF;
    req_size  = 2'b10;
  endtask

  task automatic checkOutput(input string tag);
    exp_t        e;
    int          cyc = 0;
    int          rds = 0;
    int          clash = 0;
    logic        seen = 1'b0;
    logic [31:0] rd_addr = 32'hFFFF_FFFF;
    logic        g_err = 1'b0, g_wr = 1'b0, g_done = 1'b0;
    logic [31:0] g_addr = '0, g_wdata = '0;
    logic [3:0]  g_be = '0;
    e = sbq.pop_front();
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (mem_rd_en) begin
        rds++;
        rd_addr = mem_addr;
      end
      if (mem_rd_en && mem_wr_en) clash++;
      if (mem_wr_en || misalign_err) begin
        seen    = 1'b1;
        g_err   = misalign_err;
        g_wr    = mem_wr_en;
        g_done  = done;
        g_addr  = mem_addr;
        g_wdata = mem_wdata;
        g_be    = be_seen;
      end
    end
    if (!seen) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, ".latency"}, cyc, e.lat);
    check({tag, ".err"}, {31'b0, g_err}, {31'b0, e.err});
    check({tag, ".wr_en"}, {31'b0, g_wr}, {31'b0, !e.err});
    check({tag, ".done"}, {31'b0, g_done}, {31'b0, !e.err});
    check({tag, ".rd_count"}, rds, e.rds);
    check({tag, ".strobe_clash"}, clash, 32'd0);
    if (!e.err) begin
      check({tag, ".addr"}, g_addr, e.addr);
      check({tag, ".wdata"}, g_wdata, e.wdata);
`ifdef STORE_BYTE_STROBE_EN
      check({tag, ".be"}, {28'b0, g_be}, {28'b0, e.be});
`endif
      if (rds > 0) check({tag, ".rd_addr"}, rd_addr, e.addr);
    end
    @(negedge clk);
    check({tag, ".pulse_end"}, {30'b0, mem_wr_en, misalign_err}, 32'd0);
    check({tag, ".ready_after"}, {31'b0, req_ready}, 32'd1);
    check({tag, ".be_idle"}, {28'b0, be_seen}, 32'd0);
    if (!e.err) check({tag, ".addr_hold"}, mem_addr, e.addr);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".mem_addr"}, mem_addr, 32'd0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    check({tag, ".strobes"}, {27'b0, mem_rd_en, mem_wr_en, done, misalign_err, 1'b0}, 32'd0);
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, ".be"}, {28'b0, be_seen}, 32'd0);
  endtask

  initial begin
    vec_t word_v;
    int   wr_seen;

    vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111};
    vecs[1]  = '{32'h0000_0203, 32'h0000_00A5, 2'b00, 32'h1122_3344, 1'b0, 32'hA522_3344, 32'hA5A5_A5A5, 4'b1000};
    vecs[2]  = '{32'h0000_0302, 32'h0000_CAFE, 2'b01, 32'h5566_7788, 1'b0, 32'hCAFE_7788, 32'hCAFE_CAFE, 4'b1100};
    vecs[3]  = '{32'h0000_0301, 32'h0000_CAFE, 2'b01, 32'h0000_0000, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[4]  = '{32'h0000_0104, 32'h1234_5678, 2'b11, 32'h0000_0000, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[5]  = '{32'h0000_0102, 32'h1234_5678, 2'b10, 32'h0000_0000, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[6]  = '{32'h0000_0401, 32'h1234_567F, 2'b00, 32'hAABB_CCDD, 1'b0, 32'hAABB_7FDD, 32'h7F7F_7F7F, 4'b0010};
    vecs[7]  = '{32'h0000_0500, 32'h9999_BEEF, 2'b01, 32'h0102_0304, 1'b0, 32'h0102_BEEF, 32'hBEEF_BEEF, 4'b0011};
    vecs[8]  = '{32'h0000_0600, 32'h0000_003C, 2'b00, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FF3C, 32'h3C3C_3C3C, 4'b0001};
    vecs[9]  = '{32'h0000_0702, 32'h0000_0000, 2'b00, 32'hFFFF_FFFF, 1'b0, 32'hFF00_FFFF, 32'h0000_0000, 4'b0100};
    vecs[10] = '{32'hFFFF_FFFC, 32'h1234_5678, 2'b10, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'h1234_5678, 4'b1111};
    vecs[11] = '{32'h0000_0000, 32'h0000_00FF, 2'b11, 32'h0000_0000, 1'b1, 32'h0, 32'h0, 4'b0000};

    // Power-on reset: check outputs while reset is held.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
      checkOutput($sformatf("v%0d", i));
    end

    // Reset in the middle of a byte read-modify-write: no write may follow.
    resp_word = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0203;
    req_data  = 32'h0000_00A5;
    req_size  = 2'b00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_wr_en || mem_rd_en) wr_seen++;
    end
    check("mid_reset.no_strobe_after", wr_seen, 32'd0);

    word_v = '{32'h0000_0800, 32'h0BAD_F00D, 2'b10, 32'h0, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111};
    applyStimulus(word_v, "post_reset_word");
    checkOutput("post_reset_word");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
